video_lock_ctrl: RTL and testbench

Controller placed after the video sync/DE conditioning stage and ahead of the frame writer. It measures the active geometry of the conditioned video stream: active pixels per line and active lines per frame. It declares lock after `pLOCK_FRAMES` consecutive identical frames and forwards DE only for whole frames while locked. On any geometry change or disable it closes the DE gate at once and starts measuring again.

---
 rtl/video_lock_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_video_lock_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/video_lock_ctrl.sv
// Measures active geometry of a conditioned video stream, declares lock after
// pLOCK_FRAMES identical frames and forwards DE only for whole locked frames.
module video_lock_ctrl #(
   parameter int unsigned pDATA_WIDTH  = 16,
   parameter int unsigned pCNT_WIDTH   = 12,
   parameter int unsigned pLOCK_FRAMES = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_enable,
   input  logic                   i_vsyn,
   input  logic                   i_hsyn,
   input  logic                   i_de,
   input  logic [pDATA_WIDTH-1:0] i_video_data,
   output logic                   o_vsyn,
   output logic                   o_hsyn,
   output logic                   o_de,
   output logic [pDATA_WIDTH-1:0] o_video_data,
   output logic                   o_locked,
   output logic [pCNT_WIDTH-1:0]  o_h_active,
   output logic [pCNT_WIDTH-1:0]  o_v_active,
   output logic                   o_frame_start,
   output logic                   o_err
);

   localparam int unsigned MW = 4;
   localparam logic [pCNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_MEAS, ST_LOCKED} state_t;

   state_t                 state_q, state_d;
   logic                   vsyn_q, vsyn_d, hsyn_q, hsyn_d;
   logic                   de_in_q, de_in_d, de_out_q, de_out_d;
   logic [pDATA_WIDTH-1:0] data_q, data_d;
   logic                   locked_q, locked_d, fs_q, fs_d, err_q, err_d;
   logic [pCNT_WIDTH-1:0]  h_act_q, h_act_d, v_act_q, v_act_d;
   logic [pCNT_WIDTH-1:0]  st_h_q, st_h_d, st_v_q, st_v_d;
   logic [pCNT_WIDTH-1:0]  run_q, run_d, line_q, line_d, ref_h_q, ref_h_d;
   logic                   ref_vld_q, ref_vld_d, bad_q, bad_d;
   logic [MW-1:0]          match_q, match_d;

   logic                   fb_c, line_end_c, run_bad_c, frame_bad_c, mismatch_c, gate_c;
   logic [pCNT_WIDTH-1:0]  lines_inc_c, lines_eff_c, frame_h_c;

   // Geometry measurement; a line end coincident with FB belongs to the ending frame.
   always_comb begin
      fb_c        = ~i_vsyn & vsyn_q;
      line_end_c  = ~i_de & de_in_q;
      lines_inc_c = (line_q == CNT_MAX) ? line_q : line_q + pCNT_WIDTH'(1);
      lines_eff_c = line_end_c ? lines_inc_c : line_q;
      run_bad_c   = line_end_c & ((ref_vld_q & (run_q != ref_h_q)) | (run_q == CNT_MAX));
      frame_h_c   = ref_vld_q ? ref_h_q : run_q;
      frame_bad_c = bad_q | run_bad_c | (lines_eff_c == '0) | (lines_eff_c == CNT_MAX);
      mismatch_c  = (state_q == ST_LOCKED) &
                    ((line_end_c & ((run_q != st_h_q) | (lines_inc_c > st_v_q))) |
                     (fb_c & (lines_eff_c != st_v_q)));

      run_d     = run_q;
      line_d    = line_q;
      ref_h_d   = ref_h_q;
      ref_vld_d = ref_vld_q;
      bad_d     = bad_q;
      if (fb_c || line_end_c) begin
         run_d = pCNT_WIDTH'(i_de);
      end else if (i_de && (run_q != CNT_MAX)) begin
         run_d = run_q + pCNT_WIDTH'(1);
      end
      if (fb_c) begin
         line_d    = '0;
         ref_vld_d = 1'b0;
         bad_d     = 1'b0;
      end else if (line_end_c) begin
         line_d = lines_inc_c;
         bad_d  = bad_q | run_bad_c | (lines_inc_c == CNT_MAX);
         if (!ref_vld_q) begin
            ref_h_d   = run_q;
            ref_vld_d = 1'b1;
         end
      end
   end

   // Lock FSM and gated outputs.
   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      st_h_d   = st_h_q;
      st_v_d   = st_v_q;
      h_act_d  = h_act_q;
      v_act_d  = v_act_q;
      fs_d     = 1'b0;
      err_d    = 1'b0;
      gate_c   = 1'b0;
      vsyn_d   = i_vsyn;
      hsyn_d   = i_hsyn;
      de_in_d  = i_de;
      data_d   = i_video_data;

      if (!i_enable) begin
         state_d = ST_IDLE;
         match_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               match_d = '0;
               state_d = ST_SYNC;
            end
            ST_SYNC: begin
               if (fb_c) state_d = ST_MEAS;
            end
            ST_MEAS: begin
               if (fb_c) begin
                  if (frame_bad_c) begin
                     match_d = '0;
                  end else if ((frame_h_c == st_h_q) && (lines_eff_c == st_v_q)) begin
                     match_d = match_q + MW'(1);
                  end else begin
                     st_h_d  = frame_h_c;
                     st_v_d  = lines_eff_c;
                     match_d = MW'(1);
                  end
                  if (!frame_bad_c && (match_d == MW'(pLOCK_FRAMES))) begin
                     state_d = ST_LOCKED;
                     h_act_d = frame_h_c;
                     v_act_d = lines_eff_c;
                     fs_d    = 1'b1;
                     gate_c  = 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               if (mismatch_c) begin
                  err_d   = 1'b1;
                  match_d = '0;
                  state_d = fb_c ? ST_MEAS : ST_SYNC;
               end else begin
                  gate_c = 1'b1;
                  fs_d   = fb_c;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      de_out_d = i_de & gate_c;
      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         vsyn_q    <= 1'b1;
         hsyn_q    <= 1'b1;
         de_in_q   <= 1'b0;
         de_out_q  <= 1'b0;
         data_q    <= '0;
         locked_q  <= 1'b0;
         fs_q      <= 1'b0;
         err_q     <= 1'b0;
         h_act_q   <= '0;
         v_act_q   <= '0;
         st_h_q    <= '0;
         st_v_q    <= '0;
         run_q     <= '0;
         line_q    <= '0;
         ref_h_q   <= '0;
         ref_vld_q <= 1'b0;
         bad_q     <= 1'b0;
         match_q   <= '0;
      end else begin
         state_q   <= state_d;
         vsyn_q    <= vsyn_d;
         hsyn_q    <= hsyn_d;
         de_in_q   <= de_in_d;
         de_out_q  <= de_out_d;
         data_q    <= data_d;
         locked_q  <= locked_d;
         fs_q      <= fs_d;
         err_q     <= err_d;
         h_act_q   <= h_act_d;
         v_act_q   <= v_act_d;
         st_h_q    <= st_h_d;
         st_v_q    <= st_v_d;
         run_q     <= run_d;
         line_q    <= line_d;
         ref_h_q   <= ref_h_d;
         ref_vld_q <= ref_vld_d;
         bad_q     <= bad_d;
         match_q   <= match_d;
      end
   end

   assign o_vsyn        = vsyn_q;
   assign o_hsyn        = hsyn_q;
   assign o_de          = de_out_q;
   assign o_video_data  = data_q;
   assign o_locked      = locked_q;
   assign o_h_active    = h_act_q;
   assign o_v_active    = v_act_q;
   assign o_frame_start = fs_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_video_lock_ctrl.sv
// Frame-level vector table for video_lock_ctrl plus hand sequences for
// enable drop and asynchronous reset in the middle of a locked frame.
module tb_video_lock_ctrl;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 12;

   logic          clk = 1'b0;
   logic          rst_n, enable, vsyn, hsyn, de;
   logic [DW-1:0] data;
   logic          o_vsyn, o_hsyn, o_de, o_locked, o_frame_start, o_err;
   logic [DW-1:0] o_video_data;
   logic [CW-1:0] o_h_active, o_v_active;

   int checks = 0;
   int errors = 0;
   int err_tot = 0, fs_tot = 0, de_tot = 0;

   typedef struct {
      int h, v, bl, blen;          // frame shape; line bl has blen pixels
      int lk, er, fs, de, ha, va;  // expected after the frame
   } vec_t;
   vec_t vecs[27];

   video_lock_ctrl #(.pDATA_WIDTH(DW), .pCNT_WIDTH(CW), .pLOCK_FRAMES(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_vsyn(vsyn), .i_hsyn(hsyn),
      .i_de(de), .i_video_data(data), .o_vsyn(o_vsyn), .o_hsyn(o_hsyn), .o_de(o_de),
      .o_video_data(o_video_data), .o_locked(o_locked), .o_h_active(o_h_active),
      .o_v_active(o_v_active), .o_frame_start(o_frame_start), .o_err(o_err));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_err)         err_tot <= err_tot + 1;
      if (o_frame_start) fs_tot  <= fs_tot + 1;
      if (o_de)          de_tot  <= de_tot + 1;
   end

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // Apply one input cycle; returns just after the capturing edge.
   task automatic tick(input logic vs, input logic hs, input logic d);
      vsyn = vs; hsyn = hs; de = d;
      data = data + DW'(1);
      @(posedge clk); #1;
   endtask

   task automatic frame_head();
      repeat (2) tick(1'b0, 1'b1, 1'b0);
      repeat (2) tick(1'b1, 1'b1, 1'b0);
   endtask

   task automatic line(input int len);
      repeat (len) tick(1'b1, 1'b1, 1'b1);
      repeat (2) tick(1'b1, 1'b0, 1'b0);
      repeat (2) tick(1'b1, 1'b1, 1'b0);
   endtask

   task automatic run_vec(input int i);
      int e0, f0, d0;
      e0 = err_tot; f0 = fs_tot; d0 = de_tot;
      frame_head();
      for (int l = 0; l < vecs[i].v; l++) line((l == vecs[i].bl) ? vecs[i].blen : vecs[i].h);
      check("locked", i, int'(o_locked), vecs[i].lk);
      check("err_pulses", i, err_tot - e0, vecs[i].er);
      check("frame_starts", i, fs_tot - f0, vecs[i].fs);
      check("de_cycles", i, de_tot - d0, vecs[i].de);
      check("h_active", i, int'(o_h_active), vecs[i].ha);
      check("v_active", i, int'(o_v_active), vecs[i].va);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_vsyn"}, -1, int'(o_vsyn), 1);
      check({tag, "_hsyn"}, -1, int'(o_hsyn), 1);
      check({tag, "_de"}, -1, int'(o_de), 0);
      check({tag, "_data"}, -1, int'(o_video_data), 0);
      check({tag, "_locked"}, -1, int'(o_locked), 0);
      check({tag, "_h_active"}, -1, int'(o_h_active), 0);
      check({tag, "_v_active"}, -1, int'(o_v_active), 0);
      check({tag, "_frame_start"}, -1, int'(o_frame_start), 0);
      check({tag, "_err"}, -1, int'(o_err), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e0;
      // Lock after discard + 3 frames, short-line loss, relock, 9-line loss.
      vecs[0]  = '{16, 8, -1, 0, 0, 0, 0,   0,  0, 0};
      vecs[1]  = '{16, 8, -1, 0, 0, 0, 0,   0,  0, 0};
      vecs[2]  = '{16, 8, -1, 0, 0, 0, 0,   0,  0, 0};
      vecs[3]  = '{16, 8, -1, 0, 1, 0, 1, 128, 16, 8};
      vecs[4]  = '{16, 8, -1, 0, 1, 0, 1, 128, 16, 8};
      vecs[5]  = '{16, 8,  3, 15, 0, 1, 1, 63, 16, 8};
      vecs[6]  = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[7]  = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[8]  = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[9]  = '{16, 8, -1, 0, 1, 0, 1, 128, 16, 8};
      vecs[10] = '{16, 9, -1, 0, 0, 1, 1, 144, 16, 8};
      // Alternating heights never lock, then three equal frames lock.
      vecs[11] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[12] = '{16, 7, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[13] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[14] = '{16, 7, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[15] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[16] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[17] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[18] = '{16, 8, -1, 0, 1, 0, 1, 128, 16, 8};
      // Relock after the enable drop.
      vecs[19] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[20] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[21] = '{16, 8, -1, 0, 0, 0, 0,   0, 16, 8};
      vecs[22] = '{16, 8, -1, 0, 1, 0, 1, 128, 16, 8};
      // Relock after mid-frame reset; geometry outputs start from zero.
      vecs[23] = '{16, 8, -1, 0, 0, 0, 0,   0,  0, 0};
      vecs[24] = '{16, 8, -1, 0, 0, 0, 0,   0,  0, 0};
      vecs[25] = '{16, 8, -1, 0, 0, 0, 0,   0,  0, 0};
      vecs[26] = '{16, 8, -1, 0, 1, 0, 1, 128, 16, 8};

      rst_n = 1'b0; enable = 1'b0; vsyn = 1'b1; hsyn = 1'b1; de = 1'b0; data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (3) line(10);
      check("idle_no_lock", -1, int'(o_locked), 0);
      check("data_ungated", -1, int'(o_video_data), int'(data));
      tick(1'b1, 1'b0, 1'b0);
      check("hsyn_delay", -1, int'(o_hsyn), 0);
      enable = 1'b1;
      repeat (3) line(10);

      for (int i = 0; i <= 18; i++) run_vec(i);

      // Enable drop mid-line while locked.
      e0 = err_tot;
      frame_head();
      line(16); line(16);
      repeat (5) tick(1'b1, 1'b1, 1'b1);
      check("de_before_drop", -1, int'(o_de), 1);
      check("locked_before_drop", -1, int'(o_locked), 1);
      enable = 1'b0;
      tick(1'b1, 1'b1, 1'b1);
      check("de_after_drop", -1, int'(o_de), 0);
      check("locked_after_drop", -1, int'(o_locked), 0);
      check("data_after_drop", -1, int'(o_video_data), int'(data));
      repeat (10) tick(1'b1, 1'b1, 1'b1);
      repeat (4) tick(1'b1, 1'b1, 1'b0);
      check("drop_err_pulses", -1, err_tot - e0, 0);
      check("drop_h_kept", -1, int'(o_h_active), 16);
      check("drop_v_kept", -1, int'(o_v_active), 8);
      enable = 1'b1;
      repeat (5) line(16);

      for (int i = 19; i <= 22; i++) run_vec(i);

      // Asynchronous reset in the middle of a locked frame.
      frame_head();
      line(16); line(16);
      repeat (7) tick(1'b1, 1'b1, 1'b1);
      check("de_before_reset", -1, int'(o_de), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) tick(1'b1, 1'b1, 1'b1);
      check("locked_in_reset", -1, int'(o_locked), 0);
      rst_n = 1'b1;
      repeat (6) tick(1'b1, 1'b1, 1'b1);
      repeat (4) tick(1'b1, 1'b1, 1'b0);
      line(16); line(16);
      check("locked_after_release", -1, int'(o_locked), 0);

      for (int i = 23; i <= 26; i++) run_vec(i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
